stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl.sv | 94 +++++++++
 tb/tb_stall_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// Pipeline stall/redirect controller: merges RAW hazard stalls with mult/div busy
// tracking, gates PC/IF-ID updates, inserts ID/EX bubbles and counts stalled cycles.
module stall_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        hz_stall,
  input  logic        id_md_use,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        br_taken,
  output logic        pcen,
  output logic        br,
  output logic        ifid_en,
  output logic        idex_clr,
  output logic        md_busy,
  output logic [3:0]  md_cnt,
  output logic [15:0] stall_cycles
);

  localparam logic [3:0]  DIV_CYCLES = 4'd10;
  localparam logic [3:0]  MUL_CYCLES = 4'd5;
  localparam logic [15:0] SC_MAX     = 16'hFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [3:0]  md_cnt_reg;
  logic [3:0]  md_cnt_next;
  logic [15:0] stall_cycles_reg;
  logic [15:0] stall_cycles_next;
  logic        stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      md_cnt_reg       <= 4'd0;
      stall_cycles_reg <= 16'd0;
    end else begin
      state_reg        <= state_next;
      md_cnt_reg       <= md_cnt_next;
      stall_cycles_reg <= stall_cycles_next;
    end
  end

  // A start pulse arriving while BUSY is dropped; the running count is never reloaded.
  always_comb begin
    state_next  = state_reg;
    md_cnt_next = md_cnt_reg;
    case (state_reg)
      IDLE: begin
        md_cnt_next = 4'd0;
        if (md_start) begin
          state_next  = BUSY;
          md_cnt_next = md_is_div ? DIV_CYCLES : MUL_CYCLES;
        end
      end
      BUSY: begin
        if (md_cnt_reg <= 4'd1) begin
          state_next  = IDLE;
          md_cnt_next = 4'd0;
        end else begin
          md_cnt_next = md_cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next  = IDLE;
        md_cnt_next = 4'd0;
      end
    endcase
  end

  assign md_busy = (state_reg == BUSY);

  // md_start is included so the consumer in ID stalls in the very cycle the op enters EX.
  assign stall = hz_stall | (id_md_use & (md_busy | md_start));

  always_comb begin
    stall_cycles_next = stall_cycles_reg;
    if (stall && (stall_cycles_reg != SC_MAX))
      stall_cycles_next = stall_cycles_reg + 16'd1;
  end

  assign pcen         = ~stall;
  assign ifid_en      = ~stall;
  assign idex_clr     = stall;
  assign br           = br_taken & ~stall;
  assign md_cnt       = md_cnt_reg;
  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl: inputs change just after the falling
// edge, outputs are checked 1 time unit later, well clear of the rising edge.
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hz_stall = 1'b0;
  logic        id_md_use = 1'b0;
  logic        md_start = 1'b0;
  logic        md_is_div = 1'b0;
  logic        br_taken = 1'b0;
  logic        pcen;
  logic        br;
  logic        ifid_en;
  logic        idex_clr;
  logic        md_busy;
  logic [3:0]  md_cnt;
  logic [15:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  stall_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .hz_stall     (hz_stall),
    .id_md_use    (id_md_use),
    .md_start     (md_start),
    .md_is_div    (md_is_div),
    .br_taken     (br_taken),
    .pcen         (pcen),
    .br           (br),
    .ifid_en      (ifid_en),
    .idex_clr     (idex_clr),
    .md_busy      (md_busy),
    .md_cnt       (md_cnt),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control outputs packed as {pcen, ifid_en, idex_clr, br}.
  task automatic chk_ctl(input string tag, input logic s, input logic b);
    chk(tag, {12'd0, pcen, ifid_en, idex_clr, br}, {12'd0, ~s, ~s, s, b});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    hz_stall = 1'b0; id_md_use = 1'b0; md_start = 1'b0; md_is_div = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset state while rst is held low
    #3;
    chk("rst_busy", {15'd0, md_busy}, 16'd0);
    chk("rst_cnt", {12'd0, md_cnt}, 16'd0);
    chk("rst_sc", stall_cycles, 16'd0);
    chk_ctl("rst_ctl", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Idle after release, inputs quiet
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk_ctl("idle_ctl", 1'b0, 1'b0);
      chk("idle_busy", {15'd0, md_busy}, 16'd0);
      chk("idle_sc", stall_cycles, 16'd0);
    end

    // Multiply with dependent consumer; a div start mid-way must be ignored
    @(negedge clk);
    md_start = 1'b1; md_is_div = 1'b0; id_md_use = 1'b1;
    #1;
    chk_ctl("mul_start_ctl", 1'b1, 1'b0);
    chk("mul_start_busy", {15'd0, md_busy}, 16'd0);
    @(negedge clk);
    md_start = 1'b0;
    for (int k = 5; k >= 1; k--) begin
      #1;
      chk("mul_cnt", {12'd0, md_cnt}, 16'(k));
      chk("mul_busy", {15'd0, md_busy}, 16'd1);
      chk_ctl("mul_ctl", 1'b1, 1'b0);
      md_start = (k == 3);
      md_is_div = (k == 3);
      @(negedge clk);
    end
    md_start = 1'b0; md_is_div = 1'b0;
    #1;
    chk("mul_done_cnt", {12'd0, md_cnt}, 16'd0);
    chk("mul_done_busy", {15'd0, md_busy}, 16'd0);
    chk_ctl("mul_done_ctl", 1'b0, 1'b0);
    chk("mul_sc", stall_cycles, 16'd6);
    id_md_use = 1'b0;

    // Divide with no consumer: 10 busy cycles, no stall
    do_reset();
    @(negedge clk);
    md_start = 1'b1; md_is_div = 1'b1;
    #1;
    chk_ctl("div_start_ctl", 1'b0, 1'b0);
    @(negedge clk);
    md_start = 1'b0; md_is_div = 1'b0;
    for (int k = 10; k >= 1; k--) begin
      #1;
      chk("div_cnt", {12'd0, md_cnt}, 16'(k));
      chk("div_busy", {15'd0, md_busy}, 16'd1);
      chk_ctl("div_ctl", 1'b0, 1'b0);
      @(negedge clk);
    end
    #1;
    chk("div_done_busy", {15'd0, md_busy}, 16'd0);
    chk("div_done_cnt", {12'd0, md_cnt}, 16'd0);
    chk("div_sc", stall_cycles, 16'd0);

    // Taken branch held through a 2-cycle hazard stall
    do_reset();
    @(negedge clk);
    br_taken = 1'b1; hz_stall = 1'b1;
    #1;
    chk_ctl("br_stall1", 1'b1, 1'b0);
    @(negedge clk); #1;
    chk_ctl("br_stall2", 1'b1, 1'b0);
    @(negedge clk);
    hz_stall = 1'b0;
    #1;
    chk_ctl("br_go", 1'b0, 1'b1);
    chk("br_sc", stall_cycles, 16'd2);
    @(negedge clk);
    br_taken = 1'b0;

    // Hazard and mult/div stall coinciding count once
    do_reset();
    @(negedge clk);
    hz_stall = 1'b1; md_start = 1'b1; md_is_div = 1'b0; id_md_use = 1'b1;
    #1;
    chk_ctl("both_ctl", 1'b1, 1'b0);
    @(negedge clk);
    hz_stall = 1'b0; md_start = 1'b0; id_md_use = 1'b0;
    #1;
    chk("both_sc", stall_cycles, 16'd1);
    chk("both_cnt", {12'd0, md_cnt}, 16'd5);

    // Asynchronous reset in the middle of a divide
    do_reset();
    @(negedge clk);
    md_start = 1'b1; md_is_div = 1'b1; id_md_use = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_is_div = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_pre_cnt", {12'd0, md_cnt}, 16'd7);
    chk("abort_pre_sc", stall_cycles, 16'd4);
    #1;
    rst = 1'b0; id_md_use = 1'b0;
    #1;
    chk("abort_busy", {15'd0, md_busy}, 16'd0);
    chk("abort_cnt", {12'd0, md_cnt}, 16'd0);
    chk("abort_sc", stall_cycles, 16'd0);
    @(negedge clk);
    rst = 1'b1; id_md_use = 1'b1;
    #1;
    chk_ctl("abort_rel_ctl", 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("abort_rel_busy", {15'd0, md_busy}, 16'd0);
    chk_ctl("abort_rel_ctl2", 1'b0, 1'b0);
    id_md_use = 1'b0;

    // Stall counter saturation
    do_reset();
    @(negedge clk);
    hz_stall = 1'b1;
    repeat (65534) @(negedge clk);
    #1;
    chk("sat_fffe", stall_cycles, 16'hFFFE);
    @(negedge clk); #1;
    chk("sat_ffff", stall_cycles, 16'hFFFF);
    repeat (5) @(negedge clk);
    #1;
    chk("sat_hold", stall_cycles, 16'hFFFF);
    chk_ctl("sat_ctl", 1'b1, 1'b0);
    hz_stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
